// File: rtl/pwmbridge_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pwmbridge_pkg
//  Description : Shared encodings for the H-bridge PWM stage: controller
//                states, PWM counter top value and per-leg request codes.
//  Revision    : 1.0 - initial release
// ============================================================================
package pwmbridge_pkg;

    // Controller states
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_DEAD = 2'd1;
    localparam logic [1:0] c_ST_RUN  = 2'd2;

    // PWM counter wraps from this value back to 0 (period of 255 enables)
    localparam logic [7:0] c_PWMTOP  = 8'd254;

    // Leg request codes presented to each dead-time leg
    localparam logic [1:0] c_REQ_OFF = 2'd0;
    localparam logic [1:0] c_REQ_LO  = 2'd1;
    localparam logic [1:0] c_REQ_HI  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/pwmbridge_deadleg.sv
`default_nettype none
// ============================================================================
//  Module      : deadleg
//  Description : One half-bridge leg. Turns a request code into registered
//                hi/lo gate drives, holding each gate off until its
//                complement has been off for DEADTIME consecutive clocks.
//  Revision    : 1.0 - initial release
// ============================================================================
module deadleg
    import pwmbridge_pkg::*;
#(
    parameter int DEADTIME = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       arm,
    input  logic [1:0] req,
    output logic       hi,
    output logic       lo
);

    localparam logic [7:0] c_DT = 8'(DEADTIME);

    logic       r_hi;
    logic       r_lo;
    // Remaining off-time of the complementary gate before this gate may assert
    logic [7:0] r_hiwait;
    logic [7:0] r_lowait;
    logic       w_hi_ok;
    logic       w_lo_ok;

    // A count of 1 means this is the last required off cycle, so the gate
    // may switch on at this edge.
    assign w_hi_ok = !r_lo && (r_hiwait <= 8'd1);
    assign w_lo_ok = !r_hi && (r_lowait <= 8'd1);

    // Gate registers and the two off-time counters (reloaded while the
    // complementary gate is on, or when the controller re-arms the leg)
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi     <= 1'b0;
            r_lo     <= 1'b0;
            r_hiwait <= c_DT;
            r_lowait <= c_DT;
        end else begin
            r_hi <= (req == c_REQ_HI) && w_hi_ok;
            r_lo <= (req == c_REQ_LO) && w_lo_ok;
            if (arm) begin
                r_hiwait <= c_DT;
                r_lowait <= c_DT;
            end else begin
                if (r_lo)
                    r_hiwait <= c_DT;
                else if (r_hiwait != 8'd0)
                    r_hiwait <= r_hiwait - 8'd1;
                if (r_hi)
                    r_lowait <= c_DT;
                else if (r_lowait != 8'd0)
                    r_lowait <= r_lowait - 8'd1;
            end
        end
    end

    assign hi = r_hi;
    assign lo = r_lo;

endmodule
`default_nettype wire

// File: rtl/pwmbridge.sv
`default_nettype none
// ============================================================================
//  Module      : pwmbridge
//  Description : Per-channel H-bridge PWM stage. PWM counter, double-buffered
//                duty/direction registers, start/reversal coast controller,
//                two dead-time legs and output polarity inversion.
//  Revision    : 1.0 - initial release
// ============================================================================
module pwmbridge
    import pwmbridge_pkg::*;
#(
    parameter int DEADTIME = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pwmcntce,
    input  logic       run,
    input  logic       motorena,
    input  logic       invphase,
    input  logic       invertpwm,
    input  logic       dutyld,
    input  logic       dirld,
    input  logic [7:0] wrtdata,
    output logic       ahi,
    output logic       alo,
    output logic       bhi,
    output logic       blo,
    output logic [7:0] statusrdata,
    output logic [7:0] dutyrdata
);

    localparam logic [7:0] c_DT = 8'(DEADTIME);

    logic [7:0] r_cnt;
    logic [7:0] r_dutysh;
    logic [7:0] r_dutyact;
    logic       r_dirsh;
    logic       r_diract;
    logic       r_pwmraw;
    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic [7:0] r_deadcnt;
    logic [7:0] w_deadcnt_nxt;
    logic       w_wrap;
    logic       w_en;
    logic       w_drive;
    logic       w_arm;
    logic       w_legb;
    logic [1:0] w_req_a;
    logic [1:0] w_req_b;
    logic       w_ahi;
    logic       w_alo;
    logic       w_bhi;
    logic       w_blo;

    assign w_wrap = pwmcntce && (r_cnt == c_PWMTOP);
    assign w_en   = run && motorena;

    // PWM counter, shadow/active registers and the registered compare
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt     <= 8'd0;
            r_dutysh  <= 8'd0;
            r_dutyact <= 8'd0;
            r_dirsh   <= 1'b0;
            r_diract  <= 1'b0;
            r_pwmraw  <= 1'b0;
        end else begin
            if (pwmcntce)
                r_cnt <= w_wrap ? 8'd0 : r_cnt + 8'd1;
            // Active copies take the old shadow, so a write on the wrap
            // cycle waits for the following wrap.
            if (w_wrap) begin
                r_dutyact <= r_dutysh;
                r_diract  <= r_dirsh;
            end
            if (dutyld)
                r_dutysh <= wrtdata;
            if (dirld)
                r_dirsh <= wrtdata[0];
            r_pwmraw <= (r_cnt < r_dutyact);
        end
    end

    // Controller state and coast counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_ST_IDLE;
            r_deadcnt <= c_DT;
        end else begin
            r_state   <= w_state_nxt;
            r_deadcnt <= w_deadcnt_nxt;
        end
    end

    // Next-state logic: losing run/enable always wins; start and reversal
    // both pass through the all-off coast interval.
    always_comb begin
        w_state_nxt   = r_state;
        w_deadcnt_nxt = r_deadcnt;
        if (!w_en) begin
            w_state_nxt = c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    w_state_nxt   = c_ST_DEAD;
                    w_deadcnt_nxt = c_DT;
                end
                c_ST_DEAD: begin
                    if (r_deadcnt == 8'd0)
                        w_state_nxt = c_ST_RUN;
                    else
                        w_deadcnt_nxt = r_deadcnt - 8'd1;
                end
                c_ST_RUN: begin
                    // Direction is about to change at this wrap
                    if (w_wrap && (r_dirsh != r_diract)) begin
                        w_state_nxt   = c_ST_DEAD;
                        w_deadcnt_nxt = c_DT;
                    end
                end
                default: begin
                    w_state_nxt = c_ST_IDLE;
                end
            endcase
        end
    end

    // Legs are driven only while staying in RUN, so every exit turns the
    // gates off at the same edge; the exit also re-arms both legs.
    assign w_drive = (r_state == c_ST_RUN) && (w_state_nxt == c_ST_RUN);
    assign w_arm   = (r_state == c_ST_RUN) && (w_state_nxt != c_ST_RUN);
    assign w_legb  = r_diract ^ invphase;

    // Leg requests: the drive leg follows the PWM, the other leg holds low
    always_comb begin
        w_req_a = c_REQ_OFF;
        w_req_b = c_REQ_OFF;
        if (w_drive) begin
            if (!w_legb) begin
                w_req_a = r_pwmraw ? c_REQ_HI : c_REQ_LO;
                w_req_b = c_REQ_LO;
            end else begin
                w_req_a = c_REQ_LO;
                w_req_b = r_pwmraw ? c_REQ_HI : c_REQ_LO;
            end
        end
    end

    deadleg #(
        .DEADTIME (DEADTIME)
    ) u_leg_a (
        .clk   (clk),
        .reset (reset),
        .arm   (w_arm),
        .req   (w_req_a),
        .hi    (w_ahi),
        .lo    (w_alo)
    );

    deadleg #(
        .DEADTIME (DEADTIME)
    ) u_leg_b (
        .clk   (clk),
        .reset (reset),
        .arm   (w_arm),
        .req   (w_req_b),
        .hi    (w_bhi),
        .lo    (w_blo)
    );

    assign ahi = w_ahi ^ invertpwm;
    assign alo = w_alo ^ invertpwm;
    assign bhi = w_bhi ^ invertpwm;
    assign blo = w_blo ^ invertpwm;

    assign statusrdata = {r_state, r_diract, r_pwmraw, 4'b0000};
    assign dutyrdata   = r_dutysh;

endmodule
`default_nettype wire
